// File: rtl/emissor_pulsos_botao.sv
`default_nettype none
// ============================================================================
// Module      : emissor_pulsos_botao
// Description : Push-button pulse emitter. Turns a "press N times" request
//               into clean level pulses on botao that a 3-sample debounce
//               receiver registers exactly once per press.
//               Optional build macro: EMISSOR_BOUNCE_EN adds a leading
//               1,0,1,... bounce burst of BOUNCE_CYCLES cycles to every press.
// Ports       : clk, reset (sync, active-high)
//               req_valid/req_ready/req_count : request handshake
//               cancel      : stop after the press in progress
//               botao       : registered button level
//               busy, done  : status / one-cycle completion pulse
//               pulses_sent : running count of completed presses (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module emissor_pulsos_botao #(
    parameter int CNT_W         = 3,
    parameter int HOLD_CYCLES   = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int BOUNCE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_count,
    output logic             req_ready,
    input  logic             cancel,
    output logic             botao,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

`ifdef EMISSOR_BOUNCE_EN
    localparam int c_BOUNCE_LEN = BOUNCE_CYCLES;
`else
    // No bounce burst; the product keeps the parameter list identical in both builds.
    localparam int c_BOUNCE_LEN = 0 * BOUNCE_CYCLES;
`endif

    localparam int c_HIGH_LEN = HOLD_CYCLES + c_BOUNCE_LEN;
    localparam int c_MAX_LEN  = (c_HIGH_LEN > GAP_CYCLES) ? c_HIGH_LEN : GAP_CYCLES;
    localparam int c_TIMER_W  = $clog2(c_MAX_LEN + 1);

    localparam logic [c_TIMER_W-1:0] c_HIGH_LOAD = c_TIMER_W'(c_HIGH_LEN - 1);
    localparam logic [c_TIMER_W-1:0] c_GAP_LOAD  = c_TIMER_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [CNT_W-1:0]       r_remaining;
    logic [CNT_W-1:0]       r_pulses_sent;
    logic                   r_cancel_pend;
    logic                   r_botao;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_req_ready;
    logic                   w_botao_next_high;

`ifdef EMISSOR_BOUNCE_EN
    // Phase index of the next HIGH cycle; the timer counts down from
    // c_HIGH_LOAD, so the phase is recovered from the remaining count.
    logic [c_TIMER_W-1:0]   w_next_phase;
    assign w_next_phase      = c_TIMER_W'(c_HIGH_LEN) - r_timer;
    assign w_botao_next_high = (w_next_phase >= c_TIMER_W'(c_BOUNCE_LEN)) ? 1'b1
                                                                          : ~w_next_phase[0];
`else
    assign w_botao_next_high = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_remaining   <= '0;
            r_pulses_sent <= '0;
            r_cancel_pend <= 1'b0;
            r_botao       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_req_ready   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cancel_pend <= 1'b0;
                    // r_req_ready is always 1 here, so req_valid alone is the transfer.
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (req_count != '0) begin
                            r_state     <= S_HIGH;
                            r_remaining <= req_count;
                            r_timer     <= c_HIGH_LOAD;
                            r_botao     <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (cancel) begin
                        r_cancel_pend <= 1'b1;
                    end
                    if (r_timer == '0) begin
                        r_state       <= S_GAP;
                        r_timer       <= c_GAP_LOAD;
                        r_botao       <= 1'b0;
                        r_pulses_sent <= r_pulses_sent + 1'b1;
                        r_remaining   <= r_remaining - 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        r_botao <= w_botao_next_high;
                    end
                end
                S_GAP: begin
                    if (cancel) begin
                        r_cancel_pend <= 1'b1;
                    end
                    if (r_timer == '0) begin
                        // A cancel arriving on the last GAP cycle still counts.
                        if ((r_remaining != '0) && !r_cancel_pend && !cancel) begin
                            r_state <= S_HIGH;
                            r_timer <= c_HIGH_LOAD;
                            r_botao <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_FIN: begin
                    r_state       <= S_IDLE;
                    r_req_ready   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_cancel_pend <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign botao       = r_botao;
    assign busy        = r_busy;
    assign done        = r_done;
    assign req_ready   = r_req_ready;
    assign pulses_sent = r_pulses_sent;

endmodule
`default_nettype wire

// File: tb/tb_emissor_pulsos_botao.sv
`default_nettype none
// ============================================================================
// Module      : tb_emissor_pulsos_botao
// Description : Self-checking bench for emissor_pulsos_botao. A timeline
//               model fills expected per-cycle levels and pushes one
//               completion record per request into a queue; a monitor
//               compares every cycle and pops a record on each done pulse,
//               also checking the press count seen by a 3-sample debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emissor_pulsos_botao;

    localparam int CNT_W = 3;
    localparam int HOLD  = 4;
    localparam int GAPC  = 4;
`ifdef EMISSOR_BOUNCE_EN
    localparam int BNC   = 3;
`else
    localparam int BNC   = 0;
`endif
    localparam int HL    = HOLD + BNC;
    localparam int PER   = HL + GAPC;
    localparam int MAXC  = 4096;
    localparam int MODV  = 1 << CNT_W;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic [CNT_W-1:0] req_count;
    logic             req_ready;
    logic             cancel;
    logic             botao;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;

    emissor_pulsos_botao #(
        .CNT_W        (CNT_W),
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAPC),
        .BOUNCE_CYCLES(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .cancel     (cancel),
        .botao      (botao),
        .busy       (busy),
        .done       (done),
        .pulses_sent(pulses_sent)
    );

    typedef struct {
        int done_cyc;
        int ps;
        int cum_presses;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_botao[MAXC];
    bit   exp_busy[MAXC];
    int   exp_ps[MAXC];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ps_base = 0;
    int   cum_presses = 0;
    int   next_free = 0;

    // 3-sample debounce receiver model
    logic [2:0] rx_sh = 3'b000;
    bit         rx_stable = 1'b0;
    int         rx_total = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected timeline for a request accepted in cycle t that emits p presses.
    task automatic fill(input int t, input int p, input int done_c, input int base);
        for (int cc = t + 1; cc < MAXC; cc++) begin
            int r = cc - t - 1;
            int j = r / PER;
            int k = r % PER;
            int n;
            exp_busy[cc]  = (cc <= done_c);
            exp_botao[cc] = 1'b0;
            if (j < p && k < HL)
                exp_botao[cc] = (k < BNC) ? ((k % 2) == 0) : 1'b1;
            n = 0;
            if (r >= HL) n = (r - HL) / PER + 1;
            if (n > p) n = p;
            exp_ps[cc] = (base + n) % MODV;
        end
    endtask

    // One request; cancel_c < 0 means no cancel.
    task automatic do_req(input int n, input int cancel_c_rel, input bit noisy);
        int t, p, done_c, c, last;
        exp_t e;
        t = next_free;
        c = (cancel_c_rel < 0) ? -1 : t + cancel_c_rel;
        p = n;
        if (c >= t + 1 && c <= t + PER * n) begin
            int j = (c - t - 1) / PER;
            if (j + 1 < p) p = j + 1;
        end
        done_c = t + 1 + PER * p;
        fill(t, p, done_c, ps_base);
        ps_base     = (ps_base + p) % MODV;
        cum_presses = cum_presses + p;
        e.done_cyc = done_c;
        e.ps = ps_base;
        e.cum_presses = cum_presses;
        exp_q.push_back(e);
        last = (c > done_c) ? c : done_c;
        for (int cc = t; cc <= last; cc++) begin
            goto(cc);
            cancel = (cc == c);
            if (cc == t) begin
                req_valid = 1'b1;
                req_count = CNT_W'(n);
            end else begin
                // Requests while busy must be ignored.
                req_valid = noisy && (cc <= done_c) && ($urandom_range(0, 3) == 0);
                req_count = CNT_W'($urandom_range(0, MODV - 1));
            end
        end
        goto(last + 1);
        req_valid = 1'b0;
        cancel    = 1'b0;
        next_free = done_c + 1;
    endtask

    // Request of n presses, reset asserted during its first HIGH cycle.
    task automatic do_reset_mid(input int n);
        int t;
        t = next_free;
        fill(t, n, MAXC, ps_base);
        for (int cc = t + 2; cc < MAXC; cc++) begin
            exp_botao[cc] = 1'b0;
            exp_busy[cc]  = 1'b0;
            exp_ps[cc]    = 0;
        end
        ps_base = 0;
        goto(t);
        req_valid = 1'b1;
        req_count = CNT_W'(n);
        goto(t + 1);
        req_valid = 1'b0;
        reset     = 1'b1;
        goto(t + 2);
        reset     = 1'b0;
        next_free = t + 3;
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            checks++;
            if (botao !== exp_botao[cyc]) begin
                errors++;
                $display("FAIL botao cyc=%0d got=%b exp=%b", cyc, botao, exp_botao[cyc]);
            end
            checks++;
            if (busy !== exp_busy[cyc]) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy[cyc]);
            end
            checks++;
            if (req_ready !== !exp_busy[cyc]) begin
                errors++;
                $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, !exp_busy[cyc]);
            end
            checks++;
            if (int'(pulses_sent) != exp_ps[cyc]) begin
                errors++;
                $display("FAIL pulses_sent cyc=%0d got=%0d exp=%0d", cyc, pulses_sent, exp_ps[cyc]);
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cyc != e.done_cyc) begin
                        errors++;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.done_cyc);
                    end
                    checks++;
                    if (int'(pulses_sent) != e.ps) begin
                        errors++;
                        $display("FAIL done_pulses_sent got=%0d exp=%0d", pulses_sent, e.ps);
                    end
                    checks++;
                    if (rx_total != e.cum_presses) begin
                        errors++;
                        $display("FAIL rx_presses got=%0d exp=%0d", rx_total, e.cum_presses);
                    end
                end
            end
            rx_sh = {rx_sh[1:0], botao};
            if (rx_sh == 3'b111 && !rx_stable) begin
                rx_stable = 1'b1;
                rx_total++;
            end else if (rx_sh == 3'b000) begin
                rx_stable = 1'b0;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_count = '0;
        cancel    = 1'b0;
        goto(3);
        reset     = 1'b0;
        next_free = 5;

        do_req(3, -1, 1'b0);               // basic three presses
        next_free += 2;
        do_req(0, -1, 1'b0);               // zero presses
        do_req(7, PER + 2, 1'b0);          // cancel during second HIGH
        next_free += 1;
        do_req(3, -1, 1'b1);               // pulses_sent 5 -> 0 wrap
        do_reset_mid(5);                   // reset during HIGH
        do_req(7, -1, 1'b0);
        do_req(1, -1, 1'b0);               // 7 -> 0 wrap
        for (int i = 0; i < 25; i++) begin
            int n, crel;
            n    = $urandom_range(0, MODV - 1);
            crel = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PER * n + 1)) : -1;
            next_free += $urandom_range(0, 3);
            do_req(n, crel, 1'b1);
        end
        goto(next_free + 5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_missing got=%0d exp=0 outstanding", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
